// File: rtl/line_engine.sv
// Bresenham line rasterizer: latches endpoints/colour from CPU strobes and emits one
// frame-buffer pixel write per valid/ready handshake. Define LINE_ENGINE_CLIP_EN to skip off-screen points.
module line_engine #(
  parameter logic [31:0] FB_BASE = 32'h1080_0000,
  parameter int          H_RES   = 800,
  parameter int          V_RES   = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  line_point,
  input  logic        line_x0_valid,
  input  logic        line_y0_valid,
  input  logic        line_x1_valid,
  input  logic        line_y1_valid,
  input  logic [31:0] line_color,
  input  logic        line_color_valid,
  input  logic        line_trigger,
  output logic        line_ready,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [31:0] pix_addr,
  output logic [31:0] pix_data,
  output logic [3:0]  pix_we
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
  state_t state;

  logic [9:0]  cfg_x0, cfg_y0, cfg_x1, cfg_y1;
  logic [23:0] cfg_color;

  logic [9:0]  x0_p0, y0_p0, x1_p0, y1_p0;
  logic [23:0] color_p0;

  logic               steep_p1, yneg_p1;
  logic signed [11:0] x_end_p1, dx_p1, dy_p1, err_p1, cur_x_p1, cur_y_p1;

  logic [7:0] unused_color_hi;
  assign unused_color_hi = line_color[31:24];

  function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] pix_address(input logic [9:0] px, input logic [9:0] py);
    return FB_BASE + {10'b0, py, px, 2'b00};
  endfunction

  // Setup stage: octant normalisation of the captured endpoints
  logic signed [11:0] ax0, ay0, ax1, ay1;
  logic signed [11:0] p0x, p0y, p1x, p1y;
  logic signed [11:0] s_x0, s_y0, s_x1, s_y1, s_dx, s_dy;
  logic               s_steep, s_yneg;
  logic [9:0]         s_px, s_py;

  always_comb begin
    ax0 = $signed({2'b00, x0_p0});
    ay0 = $signed({2'b00, y0_p0});
    ax1 = $signed({2'b00, x1_p0});
    ay1 = $signed({2'b00, y1_p0});
    s_steep = abs12(ay1 - ay0) > abs12(ax1 - ax0);
    p0x = s_steep ? ay0 : ax0;
    p0y = s_steep ? ax0 : ay0;
    p1x = s_steep ? ay1 : ax1;
    p1y = s_steep ? ax1 : ay1;
    if (p0x > p1x) begin
      s_x0 = p1x; s_y0 = p1y; s_x1 = p0x; s_y1 = p0y;
    end else begin
      s_x0 = p0x; s_y0 = p0y; s_x1 = p1x; s_y1 = p1y;
    end
    s_dx   = s_x1 - s_x0;
    s_dy   = abs12(s_y1 - s_y0);
    s_yneg = !(s_y0 < s_y1);
    s_px   = s_steep ? s_y0[9:0] : s_x0[9:0];
    s_py   = s_steep ? s_x0[9:0] : s_y0[9:0];
  end

  // Draw stage: next stepper point after the current one is consumed
  logic signed [11:0] t_err, n_x, n_y, n_err;
  logic [9:0]         n_px, n_py;

  always_comb begin
    t_err = err_p1 - dy_p1;
    n_x   = cur_x_p1 + 12'sd1;
    if (t_err < 0) begin
      n_y   = yneg_p1 ? cur_y_p1 - 12'sd1 : cur_y_p1 + 12'sd1;
      n_err = t_err + dx_p1;
    end else begin
      n_y   = cur_y_p1;
      n_err = t_err;
    end
    n_px = steep_p1 ? n_y[9:0] : n_x[9:0];
    n_py = steep_p1 ? n_x[9:0] : n_y[9:0];
  end

  logic s_vis, n_vis;
`ifdef LINE_ENGINE_CLIP_EN
  function automatic logic in_view(input logic [9:0] px, input logic [9:0] py);
    return (int'({22'b0, px}) < H_RES) && (int'({22'b0, py}) < V_RES);
  endfunction
  assign s_vis = in_view(s_px, s_py);
  assign n_vis = in_view(n_px, n_py);
`else
  localparam int unused_res = H_RES + V_RES;
  assign s_vis = 1'b1;
  assign n_vis = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_ready <= 1'b1;
      pix_valid  <= 1'b0;
      pix_we     <= 4'h0;
      pix_addr   <= '0;
      pix_data   <= '0;
      cfg_x0     <= '0;
      cfg_y0     <= '0;
      cfg_x1     <= '0;
      cfg_y1     <= '0;
      cfg_color  <= '0;
      x0_p0      <= '0;
      y0_p0      <= '0;
      x1_p0      <= '0;
      y1_p0      <= '0;
      color_p0   <= '0;
      steep_p1   <= 1'b0;
      yneg_p1    <= 1'b0;
      x_end_p1   <= '0;
      dx_p1      <= '0;
      dy_p1      <= '0;
      err_p1     <= '0;
      cur_x_p1   <= '0;
      cur_y_p1   <= '0;
    end else begin
      if (line_x0_valid)    cfg_x0    <= line_point;
      if (line_y0_valid)    cfg_y0    <= line_point;
      if (line_x1_valid)    cfg_x1    <= line_point;
      if (line_y1_valid)    cfg_y1    <= line_point;
      if (line_color_valid) cfg_color <= line_color[23:0];

      case (state)
        IDLE: begin
          if (line_trigger) begin
            x0_p0      <= cfg_x0;
            y0_p0      <= cfg_y0;
            x1_p0      <= cfg_x1;
            y1_p0      <= cfg_y1;
            color_p0   <= cfg_color;
            line_ready <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          steep_p1  <= s_steep;
          yneg_p1   <= s_yneg;
          x_end_p1  <= s_x1;
          dx_p1     <= s_dx;
          dy_p1     <= s_dy;
          err_p1    <= s_dx >>> 1;
          cur_x_p1  <= s_x0;
          cur_y_p1  <= s_y0;
          pix_valid <= s_vis;
          pix_we    <= s_vis ? 4'hF : 4'h0;
          pix_addr  <= pix_address(s_px, s_py);
          pix_data  <= {8'h00, color_p0};
          state     <= DRAW;
        end
        DRAW: begin
          // A skipped (invisible) point advances as if it had been accepted
          if (!pix_valid || pix_ready) begin
            if (cur_x_p1 == x_end_p1) begin
              pix_valid  <= 1'b0;
              pix_we     <= 4'h0;
              line_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              cur_x_p1  <= n_x;
              cur_y_p1  <= n_y;
              err_p1    <= n_err;
              pix_valid <= n_vis;
              pix_we    <= n_vis ? 4'hF : 4'h0;
              pix_addr  <= pix_address(n_px, n_py);
            end
          end
        end
        default: begin
          pix_valid  <= 1'b0;
          pix_we     <= 4'h0;
          line_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_engine.sv
// Directed bench for line_engine: reset, line shapes, backpressure, mid-draw writes,
// reset abort and the far-right line (clipped when LINE_ENGINE_CLIP_EN is defined).
module tb_line_engine;
  logic        clk;
  logic        rst;
  logic [9:0]  line_point;
  logic        line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid;
  logic [31:0] line_color;
  logic        line_color_valid;
  logic        line_trigger;
  logic        line_ready;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_addr;
  logic [31:0] pix_data;
  logic [3:0]  pix_we;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int hs0;

  line_engine dut (
    .clk(clk), .rst(rst), .line_point(line_point),
    .line_x0_valid(line_x0_valid), .line_y0_valid(line_y0_valid),
    .line_x1_valid(line_x1_valid), .line_y1_valid(line_y1_valid),
    .line_color(line_color), .line_color_valid(line_color_valid),
    .line_trigger(line_trigger), .line_ready(line_ready),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_data(pix_data), .pix_we(pix_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && pix_valid && pix_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [9:0] v);
    line_point    = v;
    line_x0_valid = (sel == 0);
    line_y0_valid = (sel == 1);
    line_x1_valid = (sel == 2);
    line_y1_valid = (sel == 3);
    @(negedge clk);
    line_x0_valid = 1'b0;
    line_y0_valid = 1'b0;
    line_x1_valid = 1'b0;
    line_y1_valid = 1'b0;
  endtask

  task automatic set_line(input logic [9:0] x0, y0, x1, y1);
    wr(0, x0); wr(1, y0); wr(2, x1); wr(3, y1);
  endtask

  task automatic run_line(input string tag, input logic [31:0] e0, e1, e2, e3, input int n);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    line_trigger = 1'b1;
    @(negedge clk);
    line_trigger = 1'b0;
    chk({tag, "_setup_ready"}, line_ready, 1'b0);
    chk({tag, "_setup_valid"}, pix_valid, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_valid%0d", tag, i), pix_valid, 1'b1);
      chk($sformatf("%s_addr%0d", tag, i), pix_addr, e[i]);
      chk($sformatf("%s_we%0d", tag, i), pix_we, 4'hF);
      chk($sformatf("%s_data%0d", tag, i), pix_data, 32'h0012_3456);
    end
    @(negedge clk);
    chk({tag, "_done_ready"}, line_ready, 1'b1);
    chk({tag, "_done_valid"}, pix_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; line_point = '0;
    line_x0_valid = 0; line_y0_valid = 0; line_x1_valid = 0; line_y1_valid = 0;
    line_color = '0; line_color_valid = 0; line_trigger = 0; pix_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", line_ready, 1'b1);
    chk("rst_valid", pix_valid, 1'b0);
    chk("rst_we", pix_we, 4'h0);
    chk("rst_addr", pix_addr, 32'h0);
    chk("rst_data", pix_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    line_color = 32'hFF12_3456; line_color_valid = 1'b1;
    @(negedge clk);
    line_color_valid = 1'b0;
    pix_ready = 1'b1;

    set_line(0, 0, 3, 0);
    run_line("horiz", 32'h1080_0000, 32'h1080_0004, 32'h1080_0008, 32'h1080_000C, 4);
    set_line(0, 0, 1, 3);
    run_line("steep", 32'h1080_0000, 32'h1080_1000, 32'h1080_2004, 32'h1080_3004, 4);
    set_line(3, 0, 0, 0);
    run_line("rev", 32'h1080_0000, 32'h1080_0004, 32'h1080_0008, 32'h1080_000C, 4);

    // backpressure on the second pixel, plus an ignored mid-line trigger
    set_line(0, 0, 3, 0);
    hs0 = hs_cnt;
    line_trigger = 1'b1;
    @(negedge clk);
    line_trigger = 1'b0;
    chk("bp_setup_ready", line_ready, 1'b0);
    @(negedge clk);
    chk("bp_addr0", pix_addr, 32'h1080_0000);
    @(negedge clk);
    chk("bp_addr1", pix_addr, 32'h1080_0004);
    pix_ready = 1'b0;
    @(negedge clk);
    chk("bp_hold_valid_a", pix_valid, 1'b1);
    chk("bp_hold_addr_a", pix_addr, 32'h1080_0004);
    line_trigger = 1'b1;
    @(negedge clk);
    line_trigger = 1'b0;
    chk("bp_hold_addr_b", pix_addr, 32'h1080_0004);
    chk("bp_hold_data_b", pix_data, 32'h0012_3456);
    @(negedge clk);
    chk("bp_hold_valid_c", pix_valid, 1'b1);
    chk("bp_hold_addr_c", pix_addr, 32'h1080_0004);
    chk("bp_hold_we_c", pix_we, 4'hF);
    pix_ready = 1'b1;
    @(negedge clk);
    chk("bp_addr2", pix_addr, 32'h1080_0008);
    @(negedge clk);
    chk("bp_addr3", pix_addr, 32'h1080_000C);
    @(negedge clk);
    chk("bp_done_ready", line_ready, 1'b1);
    chk("bp_done_valid", pix_valid, 1'b0);
    @(negedge clk);
    chk("bp_no_requeue_valid", pix_valid, 1'b0);
    chk("bp_no_requeue_ready", line_ready, 1'b1);
    chk("bp_handshakes", hs_cnt - hs0, 4);

    // single point with an x1 write while drawing
    set_line(5, 7, 5, 7);
    hs0 = hs_cnt;
    line_trigger = 1'b1;
    @(negedge clk);
    line_trigger = 1'b0;
    chk("pt_setup_ready", line_ready, 1'b0);
    @(negedge clk);
    chk("pt_valid", pix_valid, 1'b1);
    chk("pt_addr", pix_addr, 32'h1080_7014);
    pix_ready = 1'b0;
    line_point = 10'd9; line_x1_valid = 1'b1;
    @(negedge clk);
    line_x1_valid = 1'b0;
    chk("pt_hold_valid", pix_valid, 1'b1);
    chk("pt_hold_addr", pix_addr, 32'h1080_7014);
    pix_ready = 1'b1;
    @(negedge clk);
    chk("pt_done_ready", line_ready, 1'b1);
    chk("pt_done_valid", pix_valid, 1'b0);
    chk("pt_handshakes", hs_cnt - hs0, 1);

    // line crossing the right edge of the visible area
    set_line(798, 0, 801, 0);
`ifdef LINE_ENGINE_CLIP_EN
    hs0 = hs_cnt;
    line_trigger = 1'b1;
    @(negedge clk);
    line_trigger = 1'b0;
    @(negedge clk);
    chk("clip_addr0", pix_addr, 32'h1080_0C78);
    chk("clip_valid0", pix_valid, 1'b1);
    @(negedge clk);
    chk("clip_addr1", pix_addr, 32'h1080_0C7C);
    @(negedge clk);
    chk("clip_skip800_valid", pix_valid, 1'b0);
    chk("clip_skip800_ready", line_ready, 1'b0);
    @(negedge clk);
    chk("clip_skip801_valid", pix_valid, 1'b0);
    chk("clip_skip801_ready", line_ready, 1'b0);
    @(negedge clk);
    chk("clip_done_ready", line_ready, 1'b1);
    chk("clip_handshakes", hs_cnt - hs0, 2);
`else
    run_line("far", 32'h1080_0C78, 32'h1080_0C7C, 32'h1080_0C80, 32'h1080_0C84, 4);
`endif

    // reset mid-line after two accepted pixels
    set_line(0, 0, 3, 0);
    hs0 = hs_cnt;
    line_trigger = 1'b1;
    @(negedge clk);
    line_trigger = 1'b0;
    @(negedge clk);
    chk("rml_addr0", pix_addr, 32'h1080_0000);
    @(negedge clk);
    chk("rml_addr1", pix_addr, 32'h1080_0004);
    @(negedge clk);
    chk("rml_addr2", pix_addr, 32'h1080_0008);
    rst = 1'b1; pix_ready = 1'b0;
    @(negedge clk);
    chk("rml_valid", pix_valid, 1'b0);
    chk("rml_ready", line_ready, 1'b1);
    rst = 1'b0; pix_ready = 1'b1;
    @(negedge clk);
    chk("rml_after_valid_a", pix_valid, 1'b0);
    @(negedge clk);
    chk("rml_after_valid_b", pix_valid, 1'b0);
    chk("rml_handshakes", hs_cnt - hs0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
